// File: rtl/kernel_nios2_div_pkg.sv
// Shared types and constants for the kernel_nios2_div_cell divider.
package kernel_nios2_div_pkg;

  // Default operand/result width in bits.
  localparam int DIV_WIDTH_DEFAULT = 32;

  // Divide-by-zero quotient is this bit replicated across the full width (all ones).
  localparam logic DIVZ_QUOTIENT_FILL = 1'b1;

  // Sequencer states: accept operands, iterate, then apply sign fixups.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2
  } div_state_e;

endpackage

// File: rtl/kernel_nios2_div_step.sv
// One radix-2 restoring division step: shift in one dividend bit, trial-subtract
// the divisor, keep the difference when it does not borrow.
module kernel_nios2_div_step #(
  parameter int DIV_WIDTH = 32
) (
  input  logic [DIV_WIDTH-1:0] rem,
  input  logic                 bit_in,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic [DIV_WIDTH-1:0] rem_next,
  output logic                 q_bit
);

  // The shifted partial remainder is below 2*divisor, so one extra bit holds it
  // and a second extra bit carries the borrow of the trial subtraction.
  logic [DIV_WIDTH:0]   shifted;
  logic [DIV_WIDTH+1:0] diff;
  logic [1:0]           unused_top_bits;

  assign shifted = {rem, bit_in};
  assign diff    = {1'b0, shifted} - {2'b00, divisor};
  assign q_bit   = ~diff[DIV_WIDTH+1];

  // Whichever value is kept is below the divisor, so its top bit is always zero.
  assign rem_next        = q_bit ? diff[DIV_WIDTH-1:0] : shifted[DIV_WIDTH-1:0];
  assign unused_top_bits = {diff[DIV_WIDTH], shifted[DIV_WIDTH]};

endmodule

// File: rtl/kernel_nios2_div_cell.sv
// Iterative restoring divider with fixed latency of DIV_WIDTH+2 cycles from start.
// Signed operation is built only when KERNEL_NIOS2_DIV_SIGNED_EN is defined;
// otherwise A_div_signed is ignored and every operation is unsigned.
module kernel_nios2_div_cell
  import kernel_nios2_div_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 A_div_start,
  input  logic                 A_div_abort,
  input  logic                 A_div_signed,
  input  logic [DIV_WIDTH-1:0] A_div_src1,
  input  logic [DIV_WIDTH-1:0] A_div_src2,
  output logic [DIV_WIDTH-1:0] A_div_quotient,
  output logic [DIV_WIDTH-1:0] A_div_remainder,
  output logic                 A_div_busy,
  output logic                 A_div_done
);

  localparam logic [DIV_WIDTH-1:0] LAST_STEP = DIV_WIDTH'(DIV_WIDTH - 1);

  div_state_e state, state_next;

  logic [DIV_WIDTH-1:0] step_cnt;
  logic [DIV_WIDTH-1:0] rem_q;      // partial remainder
  logic [DIV_WIDTH-1:0] dvd_q;      // dividend bits shift out the top, quotient bits in the bottom
  logic [DIV_WIDTH-1:0] dvs_q;      // divisor magnitude
  logic                 divz_q;
  logic [DIV_WIDTH-1:0] quotient_q, remainder_q;
  logic                 done_q;

  logic [DIV_WIDTH-1:0] mag_a, mag_b;
  logic [DIV_WIDTH-1:0] q_fixed, r_fixed;
  logic [DIV_WIDTH-1:0] rem_next;
  logic                 q_bit;
  logic                 load, step_en, commit;

  // Abort only matters once an operation is in flight; in IDLE start wins.
  assign load    = (state == ST_IDLE)  && A_div_start;
  assign step_en = (state == ST_CALC)  && !A_div_abort;
  assign commit  = (state == ST_FIXUP) && !A_div_abort;

`ifdef KERNEL_NIOS2_DIV_SIGNED_EN
  logic neg_a, neg_b;
  logic q_neg_q, r_neg_q;

  assign neg_a = A_div_signed & A_div_src1[DIV_WIDTH-1];
  assign neg_b = A_div_signed & A_div_src2[DIV_WIDTH-1];
  assign mag_a = neg_a ? -A_div_src1 : A_div_src1;
  assign mag_b = neg_b ? -A_div_src2 : A_div_src2;

  // Quotient sign follows the operand signs except for divide by zero, whose
  // all-ones quotient is never negated; the remainder follows the dividend.
  assign q_fixed = divz_q  ? {DIV_WIDTH{DIVZ_QUOTIENT_FILL}}
                 : q_neg_q ? -dvd_q : dvd_q;
  assign r_fixed = r_neg_q ? -rem_q : rem_q;

  // Capture the sign corrections along with the operands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (load) begin
      q_neg_q <= neg_a ^ neg_b;
      r_neg_q <= neg_a;
    end
  end
`else
  logic unused_signed;

  assign unused_signed = A_div_signed;
  assign mag_a         = A_div_src1;
  assign mag_b         = A_div_src2;
  assign q_fixed       = divz_q ? {DIV_WIDTH{DIVZ_QUOTIENT_FILL}} : dvd_q;
  assign r_fixed       = rem_q;
`endif

  kernel_nios2_div_step #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_step (
    .rem      (rem_q),
    .bit_in   (dvd_q[DIV_WIDTH-1]),
    .divisor  (dvs_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state logic: fixed step count, abort returns straight to IDLE.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (A_div_start) state_next = ST_CALC;
      ST_CALC: begin
        if (A_div_abort)                state_next = ST_IDLE;
        else if (step_cnt == LAST_STEP) state_next = ST_FIXUP;
      end
      ST_FIXUP: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Operand capture and one restoring step per CALC cycle.
  // NOTE: these are plain registers, not memories, so all of them take the async reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_cnt <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      divz_q   <= 1'b0;
    end else if (load) begin
      step_cnt <= '0;
      rem_q    <= '0;
      dvd_q    <= mag_a;
      dvs_q    <= mag_b;
      divz_q   <= (A_div_src2 == '0);
    end else if (step_en) begin
      step_cnt <= step_cnt + 1'b1;
      rem_q    <= rem_next;
      dvd_q    <= {dvd_q[DIV_WIDTH-2:0], q_bit};
    end
  end

  // Result registers update only in a FIXUP that is not aborted; done pulses with them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= commit;
      if (commit) begin
        quotient_q  <= q_fixed;
        remainder_q <= r_fixed;
      end
    end
  end

  assign A_div_quotient  = quotient_q;
  assign A_div_remainder = remainder_q;
  assign A_div_busy      = (state != ST_IDLE);
  assign A_div_done      = done_q;

endmodule
